// File: rtl/snax_gemm_ctrl_pkg.sv
// Shared CSR indices, STATUS bit positions and sequencer states for snax_gemm_ctrl.
// Optional build macro SNAX_GEMM_CTRL_PERF_EN adds the cycle counter at CSR_PERF.
package snax_gemm_ctrl_pkg;

  localparam logic [2:0] CSR_ADDR_A = 3'd0;
  localparam logic [2:0] CSR_ADDR_B = 3'd1;
  localparam logic [2:0] CSR_ADDR_C = 3'd2;
  localparam logic [2:0] CSR_START  = 3'd3;
  localparam logic [2:0] CSR_STATUS = 3'd4;
  localparam logic [2:0] CSR_PERF   = 3'd5;

  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;
  localparam int STATUS_ERR  = 2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    COMPUTE,
    STORE
  } state_e;

endpackage

// File: rtl/snax_gemm_ctrl_csr.sv
// CSR file of the GEMM sequencer: base addresses, start, sticky status and read responses.
// With SNAX_GEMM_CTRL_PERF_EN defined, a saturating busy-cycle counter is readable at CSR_PERF.
module snax_gemm_ctrl_csr
  import snax_gemm_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        csr_valid_i,
  output logic        csr_ready_o,
  input  logic        csr_write_i,
  input  logic [2:0]  csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic        csr_rsp_valid_o,
  input  logic        csr_rsp_ready_i,
  output logic [31:0] csr_rsp_data_o,
  input  logic        busy_i,
  input  logic        op_done_i,
  output logic        start_o,
  output logic [31:0] addr_a_o,
  output logic [31:0] addr_b_o,
  output logic [31:0] addr_c_o
);

  logic [31:0] addr_a_reg, addr_b_reg, addr_c_reg;
  logic [31:0] rsp_data_reg, rdata;
  logic        rsp_valid_reg, done_reg, err_reg;
  logic        xfer, wr_en, rd_en, cfg_wr, status_wr;

  assign csr_ready_o     = !rsp_valid_reg;
  assign xfer            = csr_valid_i && csr_ready_o;
  assign wr_en           = xfer && csr_write_i;
  assign rd_en           = xfer && !csr_write_i;
  // Indices 0..3 are the configuration group that is locked while busy.
  assign cfg_wr          = wr_en && (csr_addr_i <= CSR_START);
  assign status_wr       = wr_en && (csr_addr_i == CSR_STATUS);
  assign start_o         = cfg_wr && (csr_addr_i == CSR_START) && !busy_i;

  assign csr_rsp_valid_o = rsp_valid_reg;
  assign csr_rsp_data_o  = rsp_data_reg;
  assign addr_a_o        = addr_a_reg;
  assign addr_b_o        = addr_b_reg;
  assign addr_c_o        = addr_c_reg;

`ifdef SNAX_GEMM_CTRL_PERF_EN
  logic [31:0] perf_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_reg <= '0;
    end else if (start_o) begin
      perf_reg <= '0;
    end else if (busy_i && (perf_reg != 32'hFFFF_FFFF)) begin
      perf_reg <= perf_reg + 32'd1;
    end
  end
`endif

  always_comb begin
    rdata = '0;
    case (csr_addr_i)
      CSR_ADDR_A: rdata = addr_a_reg;
      CSR_ADDR_B: rdata = addr_b_reg;
      CSR_ADDR_C: rdata = addr_c_reg;
      CSR_STATUS: begin
        rdata[STATUS_BUSY] = busy_i;
        rdata[STATUS_DONE] = done_reg;
        rdata[STATUS_ERR]  = err_reg;
      end
`ifdef SNAX_GEMM_CTRL_PERF_EN
      CSR_PERF:   rdata = perf_reg;
`endif
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_a_reg    <= '0;
      addr_b_reg    <= '0;
      addr_c_reg    <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
    end else begin
      if (cfg_wr && !busy_i) begin
        case (csr_addr_i)
          CSR_ADDR_A: addr_a_reg <= csr_wdata_i;
          CSR_ADDR_B: addr_b_reg <= csr_wdata_i;
          CSR_ADDR_C: addr_c_reg <= csr_wdata_i;
          default:    ;
        endcase
      end

      // Completion wins over a simultaneous clear so a finished op is never lost.
      if (op_done_i) begin
        done_reg <= 1'b1;
      end else if (status_wr || start_o) begin
        done_reg <= 1'b0;
      end

      if (cfg_wr && busy_i) begin
        err_reg <= 1'b1;
      end else if (status_wr) begin
        err_reg <= 1'b0;
      end

      if (rd_en) begin
        rsp_valid_reg <= 1'b1;
        rsp_data_reg  <= rdata;
      end else if (rsp_valid_reg && csr_rsp_ready_i) begin
        rsp_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/snax_gemm_ctrl.sv
// GEMM sequencer: fetches A/B tiles over TCDM, pulses the datapath, stores C in beats.
// Build macro SNAX_GEMM_CTRL_PERF_EN enables the busy-cycle counter inside the CSR block.
module snax_gemm_ctrl
  import snax_gemm_ctrl_pkg::*;
#(
  parameter int AddrWidth     = 48,
  parameter int DataWidth     = 64,
  parameter int SnaxTcdmPorts = 16,
  parameter int ResultBeats   = 2
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic                                       csr_valid_i,
  output logic                                       csr_ready_o,
  input  logic                                       csr_write_i,
  input  logic [2:0]                                 csr_addr_i,
  input  logic [31:0]                                csr_wdata_i,
  output logic                                       csr_rsp_valid_o,
  input  logic                                       csr_rsp_ready_i,
  output logic [31:0]                                csr_rsp_data_o,
  output logic [SnaxTcdmPorts-1:0]                   tcdm_req_valid_o,
  input  logic [SnaxTcdmPorts-1:0]                   tcdm_req_ready_i,
  output logic                                       tcdm_req_write_o,
  output logic [SnaxTcdmPorts*AddrWidth-1:0]         tcdm_req_addr_o,
  output logic [SnaxTcdmPorts*DataWidth-1:0]         tcdm_req_data_o,
  input  logic [SnaxTcdmPorts-1:0]                   tcdm_rsp_valid_i,
  input  logic [SnaxTcdmPorts*DataWidth-1:0]         tcdm_rsp_data_i,
  output logic [SnaxTcdmPorts/2*DataWidth-1:0]       gemm_a_o,
  output logic [SnaxTcdmPorts/2*DataWidth-1:0]       gemm_b_o,
  output logic                                       gemm_start_o,
  input  logic                                       gemm_done_i,
  input  logic [ResultBeats*SnaxTcdmPorts*DataWidth-1:0] gemm_c_i,
  output logic                                       busy_o
);

  localparam int P     = SnaxTcdmPorts;
  localparam int Half  = SnaxTcdmPorts / 2;
  localparam int BeatW = (ResultBeats > 1) ? $clog2(ResultBeats) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(ResultBeats - 1);

  state_e                              state_reg, state_next;
  logic [BeatW-1:0]                    beat_reg, beat_next;
  logic [P-1:0]                        granted_reg, granted_next;
  logic [P-1:0]                        mask_reg, mask_next;
  logic [P-1:0]                        req_valid, capture;
  logic [Half*DataWidth-1:0]           a_tile_reg, b_tile_reg;
  logic [ResultBeats*P*DataWidth-1:0]  c_reg;
  logic                                gemm_start_reg, gemm_start_next;
  logic                                start, busy, op_done, req_active, all_granted;
  logic [31:0]                         addr_a, addr_b, addr_c;

  snax_gemm_ctrl_csr u_csr (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .csr_valid_i     (csr_valid_i),
    .csr_ready_o     (csr_ready_o),
    .csr_write_i     (csr_write_i),
    .csr_addr_i      (csr_addr_i),
    .csr_wdata_i     (csr_wdata_i),
    .csr_rsp_valid_o (csr_rsp_valid_o),
    .csr_rsp_ready_i (csr_rsp_ready_i),
    .csr_rsp_data_o  (csr_rsp_data_o),
    .busy_i          (busy),
    .op_done_i       (op_done),
    .start_o         (start),
    .addr_a_o        (addr_a),
    .addr_b_o        (addr_b),
    .addr_c_o        (addr_c)
  );

  assign busy        = (state_reg != IDLE);
  assign req_active  = (state_reg == FETCH) || (state_reg == STORE);
  // Each port keeps requesting until its own grant, independently of its neighbours.
  assign req_valid    = req_active ? ~granted_reg : '0;
  assign granted_next = granted_reg | (req_valid & tcdm_req_ready_i);
  assign all_granted  = &granted_next;
  assign capture      = ((state_reg == FETCH) || (state_reg == WAIT)) ?
                        (tcdm_rsp_valid_i & ~mask_reg) : '0;
  assign mask_next    = mask_reg | capture;
  assign op_done      = (state_reg == STORE) && all_granted && (beat_reg == LastBeat);

  assign tcdm_req_valid_o = req_valid;
  assign tcdm_req_write_o = (state_reg == STORE);
  assign gemm_a_o         = a_tile_reg;
  assign gemm_b_o         = b_tile_reg;
  assign gemm_start_o     = gemm_start_reg;
  assign busy_o           = busy;

  for (genvar gi = 0; gi < P; gi++) begin : g_port
    logic [AddrWidth-1:0] fetch_addr, store_addr;

    if (gi < Half) begin : g_a
      assign fetch_addr = AddrWidth'(addr_a) + AddrWidth'(8 * gi);
    end else begin : g_b
      assign fetch_addr = AddrWidth'(addr_b) + AddrWidth'(8 * (gi - Half));
    end
    assign store_addr = AddrWidth'(addr_c) + AddrWidth'(8 * (int'(beat_reg) * P + gi));

    assign tcdm_req_addr_o[gi*AddrWidth +: AddrWidth] =
        (state_reg == FETCH) ? fetch_addr :
        (state_reg == STORE) ? store_addr : '0;
    assign tcdm_req_data_o[gi*DataWidth +: DataWidth] =
        (state_reg == STORE) ? c_reg[(int'(beat_reg) * P + gi)*DataWidth +: DataWidth] : '0;
  end

  always_comb begin
    state_next      = state_reg;
    beat_next       = beat_reg;
    gemm_start_next = 1'b0;
    case (state_reg)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   if (all_granted) state_next = WAIT;
      WAIT: begin
        if (&mask_next) begin
          state_next      = COMPUTE;
          gemm_start_next = 1'b1;
        end
      end
      COMPUTE: begin
        if (gemm_done_i) begin
          state_next = STORE;
          beat_next  = '0;
        end
      end
      STORE: begin
        if (all_granted) begin
          if (beat_reg == LastBeat) state_next = IDLE;
          else                      beat_next  = beat_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= IDLE;
      beat_reg       <= '0;
      granted_reg    <= '0;
      mask_reg       <= '0;
      a_tile_reg     <= '0;
      b_tile_reg     <= '0;
      c_reg          <= '0;
      gemm_start_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      beat_reg       <= beat_next;
      gemm_start_reg <= gemm_start_next;
      granted_reg    <= (!req_active || all_granted) ? '0 : granted_next;
      mask_reg       <= (state_reg == IDLE) ? '0 : mask_next;
      for (int i = 0; i < Half; i++) begin
        if (capture[i])
          a_tile_reg[i*DataWidth +: DataWidth] <= tcdm_rsp_data_i[i*DataWidth +: DataWidth];
        if (capture[i+Half])
          b_tile_reg[i*DataWidth +: DataWidth] <= tcdm_rsp_data_i[(i+Half)*DataWidth +: DataWidth];
      end
      if ((state_reg == COMPUTE) && gemm_done_i) c_reg <= gemm_c_i;
    end
  end

endmodule

// File: tb/tb_snax_gemm_ctrl.sv
// Directed bench for snax_gemm_ctrl with a small TCDM responder and store log.
module tb_snax_gemm_ctrl;
  import snax_gemm_ctrl_pkg::*;

  localparam int P  = 16;
  localparam int AW = 48;
  localparam int DW = 64;
  localparam int RB = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 csr_valid = 1'b0, csr_write = 1'b0, csr_rsp_ready = 1'b0;
  logic [2:0]           csr_addr = '0;
  logic [31:0]          csr_wdata = '0;
  logic                 csr_ready, csr_rsp_valid;
  logic [31:0]          csr_rsp_data;
  logic [P-1:0]         req_valid, req_ready = '1, rsp_valid;
  logic                 req_write;
  logic [P*AW-1:0]      req_addr;
  logic [P*DW-1:0]      req_data, rsp_data;
  logic [P/2*DW-1:0]    gemm_a, gemm_b;
  logic                 gemm_start, gemm_done = 1'b0, busy;
  logic [RB*P*DW-1:0]   gemm_c = '0;
  logic                 mem_en = 1'b1;

  int checks = 0;
  int failures = 0;
  int store_cnt = 0;
  int busy_total = 0;
  logic [DW-1:0] wmem [logic [AW-1:0]];

  snax_gemm_ctrl #(
    .AddrWidth(AW), .DataWidth(DW), .SnaxTcdmPorts(P), .ResultBeats(RB)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .csr_valid_i     (csr_valid),
    .csr_ready_o     (csr_ready),
    .csr_write_i     (csr_write),
    .csr_addr_i      (csr_addr),
    .csr_wdata_i     (csr_wdata),
    .csr_rsp_valid_o (csr_rsp_valid),
    .csr_rsp_ready_i (csr_rsp_ready),
    .csr_rsp_data_o  (csr_rsp_data),
    .tcdm_req_valid_o(req_valid),
    .tcdm_req_ready_i(req_ready),
    .tcdm_req_write_o(req_write),
    .tcdm_req_addr_o (req_addr),
    .tcdm_req_data_o (req_data),
    .tcdm_rsp_valid_i(rsp_valid),
    .tcdm_rsp_data_i (rsp_data),
    .gemm_a_o        (gemm_a),
    .gemm_b_o        (gemm_b),
    .gemm_start_o    (gemm_start),
    .gemm_done_i     (gemm_done),
    .gemm_c_i        (gemm_c),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  // Memory answers each granted read one cycle later with {port, 0xC3, address}.
  always @(posedge clk) begin
    for (int i = 0; i < P; i++) begin
      rsp_valid[i] <= mem_en && req_valid[i] && req_ready[i] && !req_write;
      rsp_data[i*DW +: DW] <= {8'(i), 8'hC3, req_addr[i*AW +: AW]};
      if (req_valid[i] && req_ready[i] && req_write) begin
        wmem[req_addr[i*AW +: AW]] = req_data[i*DW +: DW];
        store_cnt = store_cnt + 1;
      end
    end
  end

  always @(negedge clk) if (busy) busy_total = busy_total + 1;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] cword(input int k);
    return {32'hC0DE0000 | 32'(k), 32'(k * 3 + 1)};
  endfunction

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    csr_valid = 1'b1; csr_write = 1'b1; csr_addr = a; csr_wdata = d;
    @(negedge clk);
    csr_valid = 1'b0; csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    csr_valid = 1'b1; csr_write = 1'b0; csr_addr = a;
    @(negedge clk);
    csr_valid = 1'b0;
    chk("rd_rsp_valid", csr_rsp_valid, 1);
    d = csr_rsp_data;
    csr_rsp_ready = 1'b1;
    @(negedge clk);
    csr_rsp_ready = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    for (int k = 0; k < 40 && !gemm_start; k++) @(negedge clk);
    chk(tag, gemm_start, 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 40 && busy; k++) @(negedge clk);
    chk(tag, busy, 0);
  endtask

  initial begin
    logic [31:0] rd;
    int b0, s0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_addr", |req_addr, 0);
    chk("rst_gemm_start", gemm_start, 0);
    chk("rst_rsp_valid", csr_rsp_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    csr_rd(CSR_STATUS, rd);
    chk("rst_status", rd, 0);

    // Operation 1: all ports ready
    csr_wr(CSR_ADDR_A, 32'h80);
    csr_wr(CSR_ADDR_B, 32'h280);
    csr_wr(CSR_ADDR_C, 32'h480);
    csr_wr(CSR_START, 32'h0);
    chk("fetch_busy", busy, 1);
    chk("fetch_valid", req_valid, 16'hFFFF);
    chk("fetch_write", req_write, 0);
    chk("p3_addr", req_addr[3*AW +: AW], 48'h98);
    chk("p9_addr", req_addr[9*AW +: AW], 48'h288);
    @(negedge clk);
    chk("wait_valid", req_valid, 0);
    chk("wait_no_start", gemm_start, 0);
    @(negedge clk);
    chk("start_pulse", gemm_start, 1);
    for (int i = 0; i < P / 2; i++) begin
      chk("a_tile", gemm_a[i*DW +: DW], {8'(i), 8'hC3, 48'h80 + 48'(8 * i)});
      chk("b_tile", gemm_b[i*DW +: DW], {8'(i + 8), 8'hC3, 48'h280 + 48'(8 * i)});
    end
    @(negedge clk);
    chk("start_once", gemm_start, 0);
    chk("compute_busy", busy, 1);

    // Writes while busy
    csr_wr(CSR_START, 32'h0);
    csr_wr(CSR_ADDR_A, 32'h1234);
    csr_rd(CSR_STATUS, rd);
    chk("err_set", rd, 32'b101);
    csr_rd(CSR_ADDR_A, rd);
    chk("addr_a_kept", rd, 32'h80);
    csr_wr(CSR_STATUS, 32'h0);
    csr_rd(CSR_STATUS, rd);
    chk("err_clear", rd, 32'b001);

    // Read response held until accepted
    csr_valid = 1'b1; csr_write = 1'b0; csr_addr = CSR_ADDR_B;
    @(negedge clk);
    csr_valid = 1'b0;
    @(negedge clk);
    chk("rsp_hold", csr_rsp_valid, 1);
    chk("rsp_ready_low", csr_ready, 0);
    chk("rsp_data_b", csr_rsp_data, 32'h280);
    csr_rsp_ready = 1'b1;
    @(negedge clk);
    csr_rsp_ready = 1'b0;
    chk("rsp_drop", csr_rsp_valid, 0);

    // Compute done, two store beats
    for (int k = 0; k < RB * P; k++) gemm_c[k*DW +: DW] = cword(k);
    s0 = store_cnt;
    gemm_done = 1'b1;
    @(negedge clk);
    gemm_done = 1'b0;
    chk("st0_write", req_write, 1);
    chk("st0_valid", req_valid, 16'hFFFF);
    chk("st0_p0_addr", req_addr[0 +: AW], 48'h480);
    chk("st0_p0_data", req_data[0 +: DW], cword(0));
    chk("st0_p15_addr", req_addr[15*AW +: AW], 48'h4F8);
    @(negedge clk);
    chk("st1_p0_addr", req_addr[0 +: AW], 48'h500);
    chk("st1_p0_data", req_data[0 +: DW], cword(16));
    @(negedge clk);
    chk("op1_idle", busy, 0);
    chk("op1_store_cnt", 64'(store_cnt - s0), 32);
    chk("op1_wmem_500", wmem[48'h500], cword(16));
    csr_rd(CSR_STATUS, rd);
    chk("op1_status", rd, 32'b010);

    // Stray done in IDLE, reserved CSRs
    gemm_done = 1'b1;
    @(negedge clk);
    gemm_done = 1'b0;
    @(negedge clk);
    chk("stray_done_busy", busy, 0);
    chk("stray_done_valid", req_valid, 0);
    csr_wr(3'd6, 32'hFFFF_FFFF);
    csr_rd(3'd6, rd);
    chk("csr6_zero", rd, 0);
    csr_rd(CSR_START, rd);
    chk("start_reads_zero", rd, 0);

    // Operation 2: port 5 grant delayed four cycles
    req_ready = '1;
    req_ready[5] = 1'b0;
    csr_wr(CSR_START, 32'h0);
    chk("p5_all_valid", req_valid, 16'hFFFF);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("p5_only_valid", req_valid, 16'h0020);
      chk("p5_no_start", gemm_start, 0);
    end
    req_ready[5] = 1'b1;
    wait_start("p5_start_seen");
    chk("p5_tile", gemm_a[5*DW +: DW], {8'd5, 8'hC3, 48'hA8});
    csr_rd(CSR_STATUS, rd);
    chk("op2_status_busy", rd, 32'b001);
    gemm_done = 1'b1;
    @(negedge clk);
    gemm_done = 1'b0;
    wait_idle("op2_idle");

    // Operation 3: reset while parked in WAIT, then a fresh op
    mem_en = 1'b0;
    csr_wr(CSR_START, 32'h0);
    @(negedge clk);
    chk("park_busy", busy, 1);
    chk("park_valid", req_valid, 0);
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_a_tile", |gemm_a, 0);
    chk("rstmid_start", gemm_start, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_en = 1'b1;
    csr_rd(CSR_ADDR_A, rd);
    chk("rstmid_addr_a", rd, 0);
    csr_wr(CSR_ADDR_A, 32'h1000);
    csr_wr(CSR_ADDR_B, 32'h2000);
    csr_wr(CSR_ADDR_C, 32'h3000);
    b0 = busy_total;
    s0 = store_cnt;
    csr_wr(CSR_START, 32'h0);
    wait_start("op3_start_seen");
    chk("op3_a0", gemm_a[0 +: DW], {8'd0, 8'hC3, 48'h1000});
    chk("op3_b7", gemm_b[7*DW +: DW], {8'd15, 8'hC3, 48'h2038});
    gemm_done = 1'b1;
    @(negedge clk);
    gemm_done = 1'b0;
    wait_idle("op3_idle");
    chk("op3_store_cnt", 64'(store_cnt - s0), 32);
    chk("op3_wmem", wmem[48'h3088], cword(17));
    csr_rd(CSR_PERF, rd);
`ifdef SNAX_GEMM_CTRL_PERF_EN
    chk("op3_perf", rd, 64'(busy_total - b0));
`else
    chk("op3_perf_absent", rd, 0);
`endif
    csr_rd(CSR_STATUS, rd);
    chk("op3_status", rd, 32'b010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
